perm_lane_buf: RTL and testbench
================================

Name: perm_lane_buf

Overview:
- Parametrised multi-bank lane buffer between the NOC interface stream (pushin/firstin/din/stopin) and the permutation engine's lane-read port.
- Collects NX*NY lanes of LW bits per block into one of NBUF banks, then presents completed blocks oldest-first for random (x,y) lane reads.
- Generalises the fixed 5x5x64 single-memory arrangement: configurable lane width, lane grid, and bank count for ping-pong overlap of load and permute.
- Adds framing-error detection and backpressure.

Parameters:
- LW, 64, lane width in bits.
- NX, 5, lanes per row (x extent).
- NY, 5, rows (y extent).
- NBUF, 2, number of block banks (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- pushin  in  1  input word valid.
- firstin  in  1  marks the first lane (x=0,y=0) of a block; qualified by pushin.
- din  in  LW  input lane data.
- stopin  out  1  backpressure: all banks full, input not accepted.
- blk_valid  out  1  a completed block is available on the read side.
- blk_bank  out  $clog2(NBUF) (min 1)  index of the presented bank.
- rx  in  $clog2(NX)  read lane x.
- ry  in  $clog2(NY)  read lane y.
- rd  out  LW  read data, registered.
- blk_done  in  1  single-cycle pulse: engine has finished with the presented block; bank is released.
- err_frame  out  1  sticky: block truncated by an early firstin.
- err_nofirst  out  1  sticky: data arrived at lane 0 without firstin.
- err_ovf  out  1  sticky: pushin while stopin high.

Behaviour:
- Reset (async):
  - All banks empty; write and read bank pointers 0; lane counter 0.
  - stopin=0, blk_valid=0, blk_bank=0, rd=0, all err_* = 0.
  - Storage contents are not reset.
- Write side (accepted = pushin & !stopin):
  - Lane index L = x + NX*y, filled in increasing L. An accepted word is written to the write bank at the current L, and L then increments.
  - firstin with L==0: normal block start.
  - firstin with L!=0: the partial block is discarded and the word is written as lane 0 (L becomes 1). err_frame is set.
  - No firstin with L==0: the word is dropped, L stays 0, err_nofirst is set.
  - Writing L = NX*NY-1:
    - The bank is marked full and L resets to 0.
    - The write pointer advances mod NBUF.
- Backpressure:
  - stopin = all NBUF banks full, decoded from registered state (no combinational path from pushin).
  - pushin while stopin=1: the word is dropped and err_ovf is set.
- Read side:
  - blk_valid = bank at the read pointer is full; blk_bank = read pointer.
  - rd <= bank[read pointer][rx + NX*ry] every cycle, so data appears 1 cycle after rx/ry.
  - rx >= NX or ry >= NY: rd <= 0.
  - blk_done while blk_valid: the bank is marked empty and the read pointer advances mod NBUF.
  - blk_done while !blk_valid: ignored.
- Simultaneous events:
  - Block completion and blk_done in the same cycle both take effect. Full count is unchanged; both pointers advance.
  - With NBUF=1: completing the only bank raises stopin on the next cycle. blk_done in that same cycle is ignored, because the bank was not yet full.
  - Completion into a bank makes blk_valid visible the cycle after the last-lane write. The write of lane NX*NY-1 and the full flag commit together.
- Reset mid-block discards all partial and full blocks.
- err_* clear only on rst.

Decomposition:
- Shared package perm_pkg_types:
  - Parameter defaults LW/NX/NY/NBUF.
  - Typedef lane_t (logic [LW-1:0]).
  - Lane-index width constant LIW = $clog2(NX*NY).
  - Function lane_idx(x,y).
- One natural sub-module, perm_lane_bank: a single NX*NY x LW storage bank with a write port and a registered read port, instantiated NBUF times.
- Bank full flags, pointers, the lane counter and the error logic live in the top.

Test Plan (all with LW=64, NX=NY=5, NBUF=2):
- Stream one block, din=L for L=0..24 with firstin on L=0 -> blk_valid=1 the cycle after lane 24 and blk_bank=0. Reading (x=3,y=2) gives rd=13 one cycle later.
- Stream 2 blocks with no blk_done -> stopin=1 after the 50th word. A 51st pushin is dropped and err_ovf=1. Pulse blk_done -> stopin=0 next cycle, blk_bank=1.
- Send 10 words, then firstin with din=0xAA -> err_frame=1. Block completes after 24 more words, and lane (0,0) reads 0xAA.
- pushin without firstin at idle, din=0x55 -> err_nofirst=1, word not stored, a following firstin block loads normally.
- Last lane of block 2 written in the same cycle as blk_done for block 1 -> stopin stays 0 and blk_bank becomes 1. Block 2 data reads back intact.
- Assert rst mid-block (lane 7) -> all outputs 0 immediately, blk_valid=0. A fresh block then loads correctly into bank 0.

Source files
------------

// File: rtl/perm_pkg_types.sv
// Shared types and helpers for the permutation lane buffer.
package perm_pkg_types;

  localparam int LW_DEF   = 64;
  localparam int NX_DEF   = 5;
  localparam int NY_DEF   = 5;
  localparam int NBUF_DEF = 2;

  typedef logic [LW_DEF-1:0] lane_t;

  // Lane-index width for the default grid.
  localparam int LIW = $clog2(NX_DEF * NY_DEF);

  // Linear lane index, x fastest.
  function automatic int lane_idx(input int x, input int y, input int nx);
    return x + nx * y;
  endfunction

  // $clog2 that never returns zero, so 1-entry dimensions still get a 1-bit field.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/perm_lane_bank.sv
// One block bank: DEPTH x LW storage, one write port, registered read port.
module perm_lane_bank #(
  parameter int LW    = 64,
  parameter int DEPTH = 25,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [LW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [LW-1:0] rdata_o
);

  logic [LW-1:0] mem [DEPTH];
  logic [LW-1:0] rdata_q;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read register is cleared on reset so the output is defined from time zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/perm_lane_buf.sv
// Multi-bank lane buffer: fills NX*NY-lane blocks from the input stream and
// presents completed blocks oldest-first for random (x,y) lane reads.
module perm_lane_buf
  import perm_pkg_types::*;
#(
  parameter int LW   = LW_DEF,
  parameter int NX   = NX_DEF,
  parameter int NY   = NY_DEF,
  parameter int NBUF = NBUF_DEF,
  localparam int XW  = clog2_min1(NX),
  localparam int YW  = clog2_min1(NY),
  localparam int BW  = clog2_min1(NBUF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pushin,
  input  logic          firstin,
  input  logic [LW-1:0] din,
  output logic          stopin,
  output logic          blk_valid,
  output logic [BW-1:0] blk_bank,
  input  logic [XW-1:0] rx,
  input  logic [YW-1:0] ry,
  output logic [LW-1:0] rd,
  input  logic          blk_done,
  output logic          err_frame,
  output logic          err_nofirst,
  output logic          err_ovf
);

  localparam int NL  = NX * NY;
  localparam int LIW_L = clog2_min1(NL);

  function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
    return (p == BW'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [NBUF-1:0]  full_q, full_d;
  logic [BW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LIW_L-1:0] lane_q, lane_d;
  logic             err_frame_q, err_nofirst_q, err_ovf_q;
  logic             set_frame, set_nofirst;

  logic             accept, we, last, done;
  logic [LIW_L-1:0] waddr;

  logic             oob, oob_q;
  logic [LIW_L-1:0] raddr;
  logic [BW-1:0]    rsel_q;
  logic [NBUF-1:0][LW-1:0] bank_rd;

  // Backpressure comes straight from registered full flags.
  assign stopin    = &full_q;
  assign accept    = pushin & ~stopin;
  assign blk_valid = full_q[rptr_q];
  assign blk_bank  = rptr_q;

  // Lane sequencing, framing checks, bank fill/release bookkeeping.
  always_comb begin
    full_d      = full_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    lane_d      = lane_q;
    we          = 1'b0;
    waddr       = '0;
    set_frame   = 1'b0;
    set_nofirst = 1'b0;
    if (accept) begin
      if (firstin) begin
        // An early firstin restarts the block; partial lanes are abandoned.
        we        = 1'b1;
        waddr     = '0;
        lane_d    = LIW_L'(1);
        set_frame = (lane_q != '0);
      end else if (lane_q == '0) begin
        set_nofirst = 1'b1;
      end else begin
        we     = 1'b1;
        waddr  = lane_q;
        lane_d = lane_q + 1'b1;
      end
    end
    last = we && (waddr == LIW_L'(NL - 1));
    // Release is evaluated against pre-cycle full state, so a bank that is
    // only now completing cannot be released in the same cycle.
    done = blk_done & full_q[rptr_q];
    if (done) begin
      full_d[rptr_q] = 1'b0;
      rptr_d         = ptr_inc(rptr_q);
    end
    if (last) begin
      full_d[wptr_q] = 1'b1;
      wptr_d         = ptr_inc(wptr_q);
      lane_d         = '0;
    end
  end

  // Control state and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q        <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      lane_q        <= '0;
      err_frame_q   <= 1'b0;
      err_nofirst_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      full_q        <= full_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      lane_q        <= lane_d;
      err_frame_q   <= err_frame_q | set_frame;
      err_nofirst_q <= err_nofirst_q | set_nofirst;
      err_ovf_q     <= err_ovf_q | (pushin & stopin);
    end
  end

  assign err_frame   = err_frame_q;
  assign err_nofirst = err_nofirst_q;
  assign err_ovf     = err_ovf_q;

  // Out-of-grid coordinates read address 0 and are masked to zero at the output.
  assign oob   = (int'(rx) >= NX) || (int'(ry) >= NY);
  assign raddr = oob ? '0 : LIW_L'(lane_idx(int'(rx), int'(ry), NX));

  // Track which bank and mask the registered bank reads belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsel_q <= '0;
      oob_q  <= 1'b0;
    end else begin
      rsel_q <= rptr_q;
      oob_q  <= oob;
    end
  end

  for (genvar b = 0; b < NBUF; b++) begin : g_bank
    perm_lane_bank #(
      .LW   (LW),
      .DEPTH(NL),
      .AW   (LIW_L)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we_i   (we && (wptr_q == BW'(b))),
      .waddr_i(waddr),
      .wdata_i(din),
      .raddr_i(raddr),
      .rdata_o(bank_rd[b])
    );
  end

  assign rd = oob_q ? '0 : bank_rd[rsel_q];

endmodule

// File: tb/tb_perm_lane_buf.sv
// Directed bench for perm_lane_buf with LW=64, NX=NY=5, NBUF=2.
module tb_perm_lane_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        pushin, firstin, blk_done;
  logic [63:0] din;
  logic [2:0]  rx, ry;
  logic        stopin, blk_valid;
  logic [0:0]  blk_bank;
  logic [63:0] rd;
  logic        err_frame, err_nofirst, err_ovf;

  int ntests = 0;
  int nfail  = 0;

  perm_lane_buf #(.LW(64), .NX(5), .NY(5), .NBUF(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pushin     (pushin),
    .firstin    (firstin),
    .din        (din),
    .stopin     (stopin),
    .blk_valid  (blk_valid),
    .blk_bank   (blk_bank),
    .rx         (rx),
    .ry         (ry),
    .rd         (rd),
    .blk_done   (blk_done),
    .err_frame  (err_frame),
    .err_nofirst(err_nofirst),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic f, input logic [63:0] d);
    pushin = 1'b1; firstin = f; din = d;
    tick();
    pushin = 1'b0; firstin = 1'b0;
  endtask

  // Push lanes lo..hi with din = base + L, firstin on lane 0.
  task automatic push_range(input int lo, input int hi, input logic [63:0] base);
    for (int l = lo; l <= hi; l++) push(l == 0, base + 64'(l));
  endtask

  task automatic rd_at(input int x, input int y);
    rx = 3'(x); ry = 3'(y);
    tick();
  endtask

  task automatic pulse_done();
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pushin = 0; firstin = 0; din = '0; blk_done = 0; rx = '0; ry = '0;
    #2;
    chk("rst_stopin", stopin, 0);
    chk("rst_valid", blk_valid, 0);
    chk("rst_bank", blk_bank, 0);
    chk("rst_rd", rd, 0);
    chk("rst_errs", {err_frame, err_nofirst, err_ovf}, 0);
    #6 rst = 1'b0;

    // 1: one full block, then lane (3,2)=13
    push_range(0, 23, 0);
    chk("b1_not_yet", blk_valid, 0);
    push(1'b0, 64'd24);
    chk("b1_valid", blk_valid, 1);
    chk("b1_bank", blk_bank, 0);
    chk("b1_stop", stopin, 0);
    rd_at(3, 2);
    chk("b1_rd32", rd, 13);

    // 2: second block fills both banks
    push_range(0, 23, 100);
    chk("b2_stop_pre", stopin, 0);
    push(1'b0, 64'd124);
    chk("b2_stop", stopin, 1);
    push(1'b1, 64'hDEAD);
    chk("b2_ovf", err_ovf, 1);
    chk("b2_stop_hold", stopin, 1);
    rd_at(0, 0);
    chk("b2_b0_lane0", rd, 0);
    pulse_done();
    chk("b2_stop_rel", stopin, 0);
    chk("b2_bank1", blk_bank, 1);
    chk("b2_valid1", blk_valid, 1);
    rd_at(1, 1);
    chk("b2_rd11", rd, 106);
    pulse_done();
    chk("b2_empty", blk_valid, 0);
    chk("b2_noframe", err_frame, 0);

    // 3: truncated block restarts with 0xAA at lane 0
    push_range(0, 9, 200);
    push(1'b1, 64'hAA);
    chk("fr_err", err_frame, 1);
    chk("fr_valid0", blk_valid, 0);
    push_range(1, 24, 300);
    chk("fr_valid", blk_valid, 1);
    chk("fr_bank", blk_bank, 0);
    rd_at(0, 0);
    chk("fr_rd00", rd, 64'hAA);
    rd_at(4, 4);
    chk("fr_rd44", rd, 324);
    pulse_done();

    // 4: headless word dropped, next block normal (bank 1)
    chk("nf_clear", err_nofirst, 0);
    push(1'b0, 64'h55);
    chk("nf_err", err_nofirst, 1);
    chk("nf_valid0", blk_valid, 0);
    push_range(0, 24, 400);
    chk("nf_valid", blk_valid, 1);
    chk("nf_bank", blk_bank, 1);
    rd_at(0, 0);
    chk("nf_rd00", rd, 400);
    rd_at(2, 0);
    chk("nf_rd20", rd, 402);

    // 5: completion of bank 0 coincides with release of bank 1
    push_range(0, 23, 500);
    chk("sim_stop_pre", stopin, 0);
    pushin = 1'b1; firstin = 1'b0; din = 64'd524; blk_done = 1'b1;
    tick();
    pushin = 1'b0; blk_done = 1'b0;
    chk("sim_stop", stopin, 0);
    chk("sim_valid", blk_valid, 1);
    chk("sim_bank", blk_bank, 0);
    rd_at(3, 4);
    chk("sim_rd34", rd, 523);
    rd_at(0, 0);
    chk("sim_rd00", rd, 500);
    rd_at(5, 0);
    chk("oob_x", rd, 0);
    rd_at(0, 7);
    chk("oob_y", rd, 0);

    // 6: reset at lane 7 of a block headed for bank 1
    rx = 3'd3; ry = 3'd4;
    push_range(0, 6, 700);
    chk("rst_pre_rd", rd, 523);
    rst = 1'b1;
    #1;
    chk("mrst_rd", rd, 0);
    chk("mrst_valid", blk_valid, 0);
    chk("mrst_stop", stopin, 0);
    chk("mrst_errs", {err_frame, err_nofirst, err_ovf}, 0);
    #2 rst = 1'b0;
    push_range(0, 24, 600);
    chk("post_valid", blk_valid, 1);
    chk("post_bank", blk_bank, 0);
    rd_at(2, 3);
    chk("post_rd23", rd, 617);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Hard time bound so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
